// File: rtl/vgg_pkg.sv
// Shared types and constants for the VGG16 datapath blocks.
// Holds the default pixel width, the upsampler state encoding and a counter-width helper.
package vgg_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_EMIT0 = 2'd1,
    ST_EMIT1 = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

  // Counters and addresses are kept at least one bit wide, even when a range has a single value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One-row pixel store for the upsampler.
// It has one synchronous write port and one combinational read port, and its contents are not reset.
module line_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 3,
  parameter int AW         = 2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/upsample_2x2.sv
// 2x2 unpooling stage: buffers one input row, then replays it as two output rows of twice the width.
// Defining UPSAMPLE_ZERO_FILL_EN selects zero-insertion instead of nearest-neighbour replication.
module upsample_2x2 #(
  parameter int DATA_WIDTH = vgg_pkg::DEFAULT_DATA_WIDTH,
  parameter int IN_W       = 3,
  parameter int IN_H       = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  valid_out,
  output logic                  frame_end
);

  import vgg_pkg::*;

  localparam int CW = cnt_width(2 * IN_W);
  localparam int RW = cnt_width(IN_H);
  localparam int AW = cnt_width(IN_W);

  localparam logic [CW-1:0] LOAD_LAST = CW'(IN_W - 1);
  localparam logic [CW-1:0] EMIT_LAST = CW'(2 * IN_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IN_H - 1);

  state_t                state;
  logic [CW-1:0]         col_cnt;
  logic [RW-1:0]         row_cnt;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] emit0_pixel;
  logic [DATA_WIDTH-1:0] emit1_pixel;

  assign ready_in = (state == ST_LOAD);
  assign wr_en    = ready_in && valid_in;

  line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IN_W),
    .AW         (AW)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (AW'(col_cnt)),
    .wr_data (i_data),
    .rd_addr (AW'(col_cnt >> 1)),
    .rd_data (rd_data)
  );

`ifdef UPSAMPLE_ZERO_FILL_EN
  // Only the even columns of the first output row carry data; all other positions are zero.
  assign emit0_pixel = col_cnt[0] ? '0 : rd_data;
  assign emit1_pixel = '0;
`else
  assign emit0_pixel = rd_data;
  assign emit1_pixel = rd_data;
`endif

  // The LOAD state fills the buffer, and then EMIT0 and EMIT1 each replay it once at double width.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_LOAD;
      col_cnt   <= '0;
      row_cnt   <= '0;
      o_data    <= '0;
      valid_out <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      frame_end <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (valid_in) begin
            if (col_cnt == LOAD_LAST) begin
              col_cnt <= '0;
              state   <= ST_EMIT0;
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
        ST_EMIT0: begin
          o_data    <= emit0_pixel;
          valid_out <= 1'b1;
          if (col_cnt == EMIT_LAST) begin
            col_cnt <= '0;
            state   <= ST_EMIT1;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
        ST_EMIT1: begin
          o_data    <= emit1_pixel;
          valid_out <= 1'b1;
          if (col_cnt == EMIT_LAST) begin
            col_cnt <= '0;
            state   <= ST_LOAD;
            if (row_cnt == ROW_LAST) begin
              row_cnt   <= '0;
              frame_end <= 1'b1;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_LOAD;
          col_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/upsample_2x2.md
Name: upsample_2x2

Overview:
- Nearest-neighbour 2x2 upsampler (unpooling) for the VGG16 datapath; the inverse-direction counterpart of the 2x2 max-pooling stage.
- Consumes a raster-order stream of an IN_W x IN_H feature map and emits a raster-order stream of 2*IN_W x 2*IN_H, each input value replicated into a 2x2 block.
- Buffers one input row and replays it twice; throttles the producer via ready_in.

Parameters:
- DATA_WIDTH, 32, pixel width in bits.
- IN_W, 3, input map width in pixels (output width 2*IN_W); must be >=1.
- IN_H, 3, input map height in rows (output height 2*IN_H); must be >=1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low (rst=0 resets).
- i_data  input  DATA_WIDTH  input pixel.
- valid_in  input  1  i_data valid.
- ready_in  output  1  block can accept; transfer occurs when valid_in && ready_in on a rising edge.
- o_data  output  DATA_WIDTH  output pixel, registered.
- valid_out  output  1  o_data valid; no backpressure, consumer must always accept.
- frame_end  output  1  one-cycle pulse coincident with the last output pixel of a frame.

Behaviour:
- Reset (rst=0, async): state=LOAD, all counters 0, o_data=0, valid_out=0, frame_end=0. ready_in resets to 1 (combinational from state). Line-buffer contents don't-care.
- Counters: col_cnt [$clog2(2*IN_W)], row_cnt [$clog2(IN_H)], sized to at least 1 bit. Wrap to 0 on terminal count, never overflow.
- State LOAD:
  - ready_in=1, valid_out=0.
  - Each accepted beat writes line_buf[col_cnt]=i_data and increments col_cnt.
  - On accepting beat IN_W-1: col_cnt<=0, go to EMIT0.
  - Gaps in valid_in are allowed; nothing advances without a transfer.
- State EMIT0:
  - ready_in=0; valid_in is ignored and no data is stored. Upstream must hold its data.
  - Each cycle: o_data<=line_buf[col_cnt>>1], valid_out<=1, col_cnt++.
  - After 2*IN_W outputs: col_cnt<=0, go to EMIT1.
- State EMIT1:
  - Identical output sequence to EMIT0 (second output row).
  - After its last output: row_cnt++. If row_cnt was IN_H-1, then frame_end<=1 with that output, row_cnt<=0. Go to LOAD.
- Latency: first valid_out is registered high in the cycle after the edge that accepts the IN_W-th pixel of a row.
  - Per input row: IN_W load cycles + 4*IN_W output cycles, contiguous, with no bubble between EMIT0 and EMIT1.
- Back-to-back frames: LOAD for the next frame starts the cycle after frame_end with no extra idle cycle.
- Reset mid-row or mid-emit: abandon immediately. Outputs go to 0 asynchronously; the partial row is discarded.
- IN_W=1: LOAD takes 1 beat; each EMIT state takes 2 cycles.

Optional Feature:
- Macro: UPSAMPLE_ZERO_FILL_EN.
- Defined: zero-insertion unpooling. The input value appears only at even output column in EMIT0. Odd columns of EMIT0 and all of EMIT1 output 0 with valid_out=1. Timing is identical.
- Undefined: nearest-neighbour replication as above.

Decomposition:
- Shared package vgg_pkg:
  - DATA_WIDTH default.
  - State encoding constants ST_LOAD=2'd0, ST_EMIT0=2'd1, ST_EMIT1=2'd2 (2'd3 is illegal and recovers to ST_LOAD).
- One sub-module, line_buffer:
  - IN_W x DATA_WIDTH register array.
  - 1 synchronous write port, 1 combinational read port.
  - No reset on contents.

Test Plan:
- IN_W=3, IN_H=3, rst low for 10 ns, then inputs 0..8 with valid_in held high → 36 outputs: 0 0 1 1 2 2 / 0 0 1 1 2 2 / 3 3 4 4 5 5 / 3 3 4 4 5 5 / 6 6 7 7 8 8 / 6 6 7 7 8 8; frame_end high only on the 36th output.
- Same stream with ready_in honoured and valid_in held during EMIT → no pixel lost or duplicated. valid_in pulses while ready_in=0 → line buffer unchanged, output identical to the first scenario.
- Upsampler output fed into the 2x2 max-pooling stage → pooled outputs 0..8 in order.
- rst asserted during EMIT1 of row 1 → o_data=0, valid_out=0 immediately. Next frame 100..108 → first output row 100 100 101 101 102 102.
- Two frames back-to-back (0..8, then 9..17) → 72 outputs, frame_end at output 36 and 72, no gap.
- UPSAMPLE_ZERO_FILL_EN defined, inputs 0..8 → row0 output 0 0 1 0 2 0, row1 all zeros; pattern repeats per input row.
